// File: rtl/sdram_arbiter_if.sv
// Avalon-MM bus bundle; N lanes of command signals, one shared readdata.
// The arbiter uses the slave view toward requesters and the master view toward SDRAM.
interface sdram_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N*ADDR_W-1:0] address;
  logic [N-1:0]        read;
  logic [N-1:0]        write;
  logic [N*DATA_W-1:0] writedata;
  logic [N-1:0]        waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic [N-1:0]        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master between NUM_REQ requesters,
// one transaction outstanding at a time.
//
// state   | meaning
// IDLE    | pick next pending requester after last, no command issued
// WR      | write driven to SDRAM until accepted or requester drops write
// RD_CMD  | read command driven until SDRAM accepts it
// RD_DATA | waiting for readdatavalid, routed to the granted requester
module sdram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  sdram_arbiter_if.slave  req,
  sdram_arbiter_if.master sdram,
  output logic [2:0]      grant,
  output logic            busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_DATA} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       winner, cand;
  logic                found;
  logic [NUM_REQ-1:0]  pend;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  logic                m_read, m_write;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [NUM_REQ-1:0]  r_wait, r_rdv;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign addr_arr[i] = req.address[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req.writedata[i*DATA_W +: DATA_W];
  end

  assign pend = req.read | req.write;

  // Walk the search order backwards so the nearest pending requester after last wins.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (pend[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    r_wait  = '1;
    r_rdv   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = req.read[winner] ? RD_CMD : WR;
        end
      end
      WR: begin
        m_write         = 1'b1;
        m_addr          = addr_arr[grant_q];
        m_wdata         = data_arr[grant_q];
        r_wait[grant_q] = sdram.waitrequest[0];
        // A dropped write is abandoned rather than left hanging on the bus.
        if (!sdram.waitrequest[0] || !req.write[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      RD_CMD: begin
        m_read = 1'b1;
        m_addr = addr_arr[grant_q];
        if (!sdram.waitrequest[0]) begin
          if (sdram.readdatavalid[0]) begin
            r_rdv[grant_q]  = 1'b1;
            r_wait[grant_q] = 1'b0;
            last_d          = grant_q;
            state_d         = IDLE;
          end else begin
            state_d = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        if (sdram.readdatavalid[0]) begin
          r_rdv[grant_q]  = 1'b1;
          r_wait[grant_q] = 1'b0;
          last_d          = grant_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdram.read        = m_read;
  assign sdram.write       = m_write;
  assign sdram.address     = m_addr;
  assign sdram.writedata   = m_wdata;
  assign req.waitrequest   = r_wait;
  assign req.readdatavalid = r_rdv;
  assign req.readdata      = sdram.readdata;

  assign grant = 3'(grant_q);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: cycle vector table, directed corner sequences,
// then random requesters and SDRAM against a transaction-level model.
module tb_sdram_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] grant;
  logic busy;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.N(N), .ADDR_W(32), .DATA_W(32)) rq ();
  sdram_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) sd ();

  sdram_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq),
    .sdram (sd),
    .grant (grant),
    .busy  (busy)
  );

  logic [31:0] b_addr [N];
  logic [31:0] b_data [N];
  logic [N-1:0] b_rd, b_wr;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign rq.address[g*32 +: 32]   = b_addr[g];
    assign rq.writedata[g*32 +: 32] = b_data[g];
  end
  assign rq.read  = b_rd;
  assign rq.write = b_wr;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench 2 time units after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    b_rd = '0;
    b_wr = '0;
    sd.waitrequest = 1'b0;
    sd.readdatavalid = 1'b0;
    sd.readdata = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  rd, wr;
    logic        mw, mrdv;
    logic [31:0] mrdata;
    logic        busy, mwr, mrd;
    logic [2:0]  grant;
    logic [3:0]  wt, rdv;
  } vec_t;

  localparam int NROW = 22;
  vec_t tbl [NROW];

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  int got [8];
  int n_got;

  // random-phase state
  logic        r_pend [N];
  logic        r_isrd [N];
  logic [31:0] r_addr [N];
  logic [31:0] r_data [N];
  int          wcnt [N];
  logic [3:0]  done_v, pv, exp_wait, exp_rdv;
  int          m_busy, m_rd, m_dp, m_owner, m_last;
  int          sd_pend, sd_lat, lat, ntx;
  logic [31:0] sd_addr;
  logic        mwv, rdvv;

  initial begin
    b_addr[0] = 32'h10; b_addr[1] = 32'h24; b_addr[2] = 32'h40; b_addr[3] = 32'h3C;
    b_data[0] = 32'hA0; b_data[1] = 32'hA1; b_data[2] = 32'h5;  b_data[3] = 32'hA3;

    //           rd    wr    mw    rdv   mrdata          busy  mwr   mrd   grant wt    rdv
    tbl[0]  = '{4'h0, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[1]  = '{4'h0, 4'h4, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[2]  = '{4'h0, 4'h4, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 3'd2, 4'hB, 4'h0};
    tbl[3]  = '{4'h0, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd2, 4'hF, 4'h0};
    tbl[4]  = '{4'h1, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd2, 4'hF, 4'h0};
    tbl[5]  = '{4'h1, 4'h0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 3'd0, 4'hF, 4'h0};
    tbl[6]  = '{4'h1, 4'h0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[7]  = '{4'h1, 4'h0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[8]  = '{4'h1, 4'h0, 1'b0, 1'b1, 32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0, 3'd0, 4'hE, 4'h1};
    tbl[9]  = '{4'h0, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[10] = '{4'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678,  1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[11] = '{4'h2, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};
    tbl[12] = '{4'h2, 4'h0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 3'd1, 4'hF, 4'h0};
    tbl[13] = '{4'h2, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D,  1'b1, 1'b0, 1'b1, 3'd1, 4'hD, 4'h2};
    tbl[14] = '{4'h0, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd1, 4'hF, 4'h0};
    tbl[15] = '{4'h0, 4'h8, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd1, 4'hF, 4'h0};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 3'd3, 4'hF, 4'h0};
    tbl[17] = '{4'h0, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd3, 4'hF, 4'h0};
    tbl[18] = '{4'h1, 4'h1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd3, 4'hF, 4'h0};
    tbl[19] = '{4'h1, 4'h1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 3'd0, 4'hF, 4'h0};
    tbl[20] = '{4'h1, 4'h1, 1'b0, 1'b1, 32'h77,         1'b1, 1'b0, 1'b0, 3'd0, 4'hE, 4'h1};
    tbl[21] = '{4'h0, 4'h0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'h0};

    // reset values, with requests present that must be ignored
    rst_n = 1'b0;
    b_rd = '0;
    b_wr = 4'hF;
    sd.waitrequest = 1'b0;
    sd.readdatavalid = 1'b1;
    sd.readdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #3;
    chk("reset busy",  32'(busy), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset wait",  32'(rq.waitrequest), 32'hF);
    chk("reset rdv",   32'(rq.readdatavalid), 32'h0);
    chk("reset mwr",   32'(sd.write), 32'd0);
    chk("reset mrd",   32'(sd.read), 32'd0);
    chk("reset addr",  sd.address, 32'h0);
    chk("reset wdata", sd.writedata, 32'h0);

    do_reset();
    for (int r = 0; r < NROW; r++) begin
      b_rd = tbl[r].rd;
      b_wr = tbl[r].wr;
      sd.waitrequest = tbl[r].mw;
      sd.readdatavalid = tbl[r].mrdv;
      sd.readdata = tbl[r].mrdata;
      #1;
      chk($sformatf("row%0d busy", r),  32'(busy), 32'(tbl[r].busy));
      chk($sformatf("row%0d mwr", r),   32'(sd.write), 32'(tbl[r].mwr));
      chk($sformatf("row%0d mrd", r),   32'(sd.read), 32'(tbl[r].mrd));
      chk($sformatf("row%0d grant", r), 32'(grant), 32'(tbl[r].grant));
      chk($sformatf("row%0d wait", r),  32'(rq.waitrequest), 32'(tbl[r].wt));
      chk($sformatf("row%0d rdv", r),   32'(rq.readdatavalid), 32'(tbl[r].rdv));
      if (tbl[r].mwr | tbl[r].mrd)
        chk($sformatf("row%0d addr", r), sd.address, b_addr[tbl[r].grant[1:0]]);
      else
        chk($sformatf("row%0d addr0", r), sd.address, 32'h0);
      if (tbl[r].mwr)
        chk($sformatf("row%0d wdata", r), sd.writedata, b_data[tbl[r].grant[1:0]]);
      if (tbl[r].rdv != 4'h0)
        chk($sformatf("row%0d rdata", r), rq.readdata, tbl[r].mrdata);
      @(posedge clk);
      #2;
    end

    // round-robin: everyone writes continuously
    do_reset();
    b_wr = 4'hF;
    n_got = 0;
    for (int c = 0; c < 40 && n_got < 8; c++) begin
      #1;
      if (sd.write[0]) begin
        got[n_got] = int'(grant);
        n_got++;
      end
      @(posedge clk);
      #2;
    end
    chk("rr count", 32'(n_got), 32'd8);
    for (int k = 0; k < n_got; k++) chk($sformatf("rr grant%0d", k), 32'(got[k]), 32'(k % N));

    // backpressure on req 1's write while req 2 waits
    do_reset();
    b_wr = 4'b0110;
    sd.waitrequest = 1'b1;
    #1;
    chk("bp idle", 32'(sd.write), 32'd0);
    @(posedge clk);
    #2;
    for (int k = 0; k < 6; k++) begin
      sd.waitrequest = (k < 5);
      #1;
      chk($sformatf("bp mwr%0d", k),  32'(sd.write), 32'd1);
      chk($sformatf("bp addr%0d", k), sd.address, b_addr[1]);
      chk($sformatf("bp w1_%0d", k),  32'(rq.waitrequest[1]), (k < 5) ? 32'd1 : 32'd0);
      chk($sformatf("bp w2_%0d", k),  32'(rq.waitrequest[2]), 32'd1);
      @(posedge clk);
      #2;
    end
    b_wr = 4'b0100;
    #1;
    chk("bp idle2", 32'(busy), 32'd0);
    @(posedge clk);
    #3;
    chk("bp grant2", 32'(grant), 32'd2);
    chk("bp addr2",  sd.address, b_addr[2]);

    // reset during RD_DATA; late read data must be dropped
    do_reset();
    b_rd = 4'h1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #3;
    chk("rst rd_data busy", 32'(busy), 32'd1);
    chk("rst rd_data mrd",  32'(sd.read), 32'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    b_rd = 4'h0;
    sd.readdatavalid = 1'b1;
    sd.readdata = 32'h1111_2222;
    #1;
    chk("rst rdv0",  32'(rq.readdatavalid), 32'h0);
    chk("rst busy0", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    chk("rst rdv1",  32'(rq.readdatavalid), 32'h0);
    chk("rst busy1", 32'(busy), 32'd0);
    sd.readdatavalid = 1'b0;
    b_wr = 4'b0011;
    @(posedge clk);
    #3;
    chk("rst next grant", 32'(grant), 32'd0);
    chk("rst next mwr",   32'(sd.write), 32'd1);

    // mixed: last=2, req 3 reads and req 0 writes together
    do_reset();
    b_wr = 4'h4;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    b_wr = 4'h1;
    b_rd = 4'h8;
    @(posedge clk);
    #3;
    chk("mix grant3", 32'(grant), 32'd3);
    chk("mix mrd",    32'(sd.read), 32'd1);
    chk("mix addr3",  sd.address, b_addr[3]);
    @(posedge clk);
    #2;
    sd.readdatavalid = 1'b1;
    sd.readdata = 32'h3333_0003;
    #1;
    chk("mix rdv3",  32'(rq.readdatavalid), 32'h8);
    chk("mix rdata", rq.readdata, 32'h3333_0003);
    @(posedge clk);
    #2;
    sd.readdatavalid = 1'b0;
    b_rd = 4'h0;
    @(posedge clk);
    #3;
    chk("mix grant0", 32'(grant), 32'd0);
    chk("mix mwr0",   32'(sd.write), 32'd1);

    // random traffic against transaction-level model
    do_reset();
    for (int i = 0; i < N; i++) begin
      r_pend[i] = 1'b0; r_isrd[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0; wcnt[i] = 0;
    end
    m_busy = 0; m_rd = 0; m_dp = 0; m_owner = 0; m_last = N - 1;
    sd_pend = 0; sd_lat = 0; sd_addr = '0; ntx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!r_pend[i] && $urandom_range(0, 3) == 0) begin
          r_pend[i] = 1'b1;
          r_isrd[i] = 1'($urandom_range(0, 1));
          r_addr[i] = 32'($urandom_range(0, 7)) << 2;
          r_data[i] = $urandom;
          wcnt[i]   = 0;
        end
        b_rd[i]   = r_pend[i] & r_isrd[i];
        b_wr[i]   = r_pend[i] & ~r_isrd[i];
        b_addr[i] = r_addr[i];
        b_data[i] = r_data[i];
      end
      mwv = ($urandom_range(0, 2) == 0);
      rdvv = 1'b0;
      sd.readdata = $urandom;
      if (sd_pend != 0 && sd_lat == 0) begin
        rdvv = 1'b1;
        sd.readdata = mem_rd(sd_addr);
      end
      lat = -1;
      if (sd.read[0] && !mwv && sd_pend == 0) begin
        lat = $urandom_range(0, 3);
        if (lat == 0) begin
          rdvv = 1'b1;
          sd.readdata = mem_rd(sd.address);
        end
      end
      sd.waitrequest = mwv;
      sd.readdatavalid = rdvv;
      #1;
      pv = b_rd | b_wr;
      exp_wait = '1;
      exp_rdv = '0;
      if (m_busy != 0 && m_rd == 0) exp_wait[m_owner] = mwv;
      if (m_busy != 0 && m_rd != 0 && rdvv && (m_dp != 0 || !mwv)) begin
        exp_rdv[m_owner]  = 1'b1;
        exp_wait[m_owner] = 1'b0;
      end
      chk("rnd busy",  32'(busy), 32'(m_busy != 0));
      chk("rnd grant", 32'(grant), 32'(m_owner));
      chk("rnd mwr",   32'(sd.write), 32'(m_busy != 0 && m_rd == 0));
      chk("rnd mrd",   32'(sd.read), 32'(m_busy != 0 && m_rd != 0 && m_dp == 0));
      chk("rnd wait",  32'(rq.waitrequest), 32'(exp_wait));
      chk("rnd rdv",   32'(rq.readdatavalid), 32'(exp_rdv));
      if (sd.write[0] || sd.read[0]) chk("rnd addr", sd.address, r_addr[m_owner]);
      if (sd.write[0]) chk("rnd wdata", sd.writedata, r_data[m_owner]);

      done_v = '0;
      for (int i = 0; i < N; i++) begin
        if (r_pend[i] && r_isrd[i] && rq.readdatavalid[i]) begin
          chk($sformatf("rnd rdata req%0d", i), rq.readdata, mem_rd(r_addr[i]));
          done_v[i] = 1'b1;
        end
        if (r_pend[i] && !r_isrd[i] && !rq.waitrequest[i]) done_v[i] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (done_v[i]) begin
          chk($sformatf("rnd fair req%0d", i), 32'(wcnt[i] <= N - 1), 32'd1);
          for (int j = 0; j < N; j++)
            if (j != i && r_pend[j]) wcnt[j]++;
          r_pend[i] = 1'b0;
          ntx++;
        end
      end

      if (sd.write[0] && !mwv) mem[sd.address] = sd.writedata;
      if (sd_pend != 0) begin
        if (sd_lat == 0) sd_pend = 0;
        else sd_lat--;
      end else if (lat > 0) begin
        sd_pend = 1;
        sd_lat  = lat - 1;
        sd_addr = sd.address;
      end

      if (m_busy == 0) begin
        if (pv != 4'h0) begin
          m_owner = rr_pick(pv, m_last);
          m_rd    = int'(b_rd[m_owner]);
          m_dp    = 0;
          m_busy  = 1;
        end
      end else if (m_rd == 0) begin
        if (!mwv) begin m_last = m_owner; m_busy = 0; end
      end else if (m_dp == 0) begin
        if (!mwv) begin
          if (rdvv) begin m_last = m_owner; m_busy = 0; end
          else m_dp = 1;
        end
      end else if (rdvv) begin
        m_last = m_owner;
        m_busy = 0;
      end
      @(posedge clk);
      #2;
    end
    chk("rnd progress", 32'(ntx > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares one Avalon-MM SDRAM master port between NUM_REQ move-generator accelerators (pawn, knight, bishop, etc.), which would otherwise each own a master. Arbitration is round-robin at transaction granularity. At most one transaction is outstanding at a time. Each requester sees a standard Avalon master interface (waitrequest, read, readdatavalid, write), so generator RTL is unchanged.

Parameters:
NUM_REQ, 4, number of requester master ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_address  in  NUM_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W]
req_read  in  NUM_REQ  per-requester read request
req_write  in  NUM_REQ  per-requester write request
req_writedata  in  NUM_REQ*DATA_W  per-requester write data
req_waitrequest  out  NUM_REQ  per-requester stall
req_readdata  out  DATA_W  read data, broadcast to all requesters
req_readdatavalid  out  NUM_REQ  one-hot read-data strobe
master_waitrequest  in  1  SDRAM stall
master_address  out  ADDR_W  SDRAM address
master_read  out  1  SDRAM read
master_write  out  1  SDRAM write
master_writedata  out  DATA_W  SDRAM write data
master_readdata  in  DATA_W  SDRAM read data
master_readdatavalid  in  1  SDRAM read data valid
grant  out  3  index of the current or last granted requester (debug)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last=NUM_REQ-1, so requester 0 wins first; grant=0.
  - master_read=0, master_write=0, master_address=0, master_writedata=0.
  - req_waitrequest all 1, req_readdatavalid all 0.
  - Reset mid-transaction drops it silently; a read response arriving after reset is ignored.
- States: IDLE, WR, RD_CMD, RD_DATA.
- IDLE:
  - Requester i is pending if req_read[i] | req_write[i].
  - Search order: last+1, last+2, … mod NUM_REQ; the first pending requester wins and is registered into grant.
  - Next state is RD_CMD if its req_read=1 (read wins if both are set, which is a protocol violation), else WR. No pending requester: stay in IDLE.
  - Arbitration costs 1 cycle; no master command is issued in IDLE.
- WR:
  - master_write=1; master_address and master_writedata are driven from the grant slice.
  - req_waitrequest[grant]=master_waitrequest.
  - On master_waitrequest=0: last=grant, go to IDLE.
  - If the granted requester drops req_write while still in WR: abort to IDLE, last=grant.
- RD_CMD:
  - master_read=1; address from the grant slice.
  - req_waitrequest[grant]=1, keeping the requester holding read (generators hold read until readdatavalid).
  - On master_waitrequest=0, go to RD_DATA.
  - If master_readdatavalid=1 in the same cycle as acceptance, handle it as in RD_DATA and go straight to IDLE.
- RD_DATA:
  - master_read=0; req_waitrequest[grant]=1.
  - On master_readdatavalid=1: req_readdatavalid[grant]=1 for that cycle only, req_readdata=master_readdata, req_waitrequest[grant]=0 for that cycle; last=grant, go to IDLE.
- Ungranted requesters: waitrequest=1 and readdatavalid=0 at all times.
- master_readdatavalid outside RD_CMD/RD_DATA is ignored.
- Master command outputs are combinational from state/grant; they are 0 and address/data hold 0 when not in WR/RD_CMD.
- Fairness: each pending requester is served within NUM_REQ transactions.
- Throughput: writes take 2 cycles minimum; reads take 2 cycles plus SDRAM latency.
- busy=(state!=IDLE).

Test Plan:
- Single write: req 2 writes addr 0x40, data 0x5 with master_waitrequest=0 → master_write=1 with addr 0x40, data 0x5 in cycle 2; req_waitrequest[2]=0 that cycle; busy=0 in cycle 3.
- Single read, 3-cycle latency: req 0 reads 0x10, SDRAM returns 0xFFFFFFFE → exactly one req_readdatavalid[0] pulse with readdata 0xFFFFFFFE; no other valid bit ever set.
- Round-robin: all 4 requesters hold continuous writes → grant sequence 0,1,2,3,0; no requester is granted twice before all others have been granted once.
- Backpressure: master_waitrequest=1 for 5 cycles during WR from req 1 → master_write and address held stable for 6 cycles; other requests wait; then req 2 is granted.
- Reset mid-read: assert rst_n=0 in RD_DATA, release, then inject master_readdatavalid → no req_readdatavalid pulse; state IDLE; next grant goes to req 0.
- Mixed: req 3 reads while req 0 writes, last=2 → req 3 is served first (read completes), then req 0's write.
